// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b, one bit per clock, LSB first.
// One full-subtractor cell plus a borrow flop; start/busy/done handshake, result held until next done.
module serial_subtractor_nbit #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 overflow
);

    localparam int CW = $clog2(BIT_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [BIT_WIDTH-1:0] a_sr, b_sr;
    logic [BIT_WIDTH-2:0] res_sr;
    logic [BIT_WIDTH-1:0] res_full;
    logic [CW-1:0]        count;
    logic                 borrow;
    logic                 a_msb, b_msb;
    logic                 d, borrow_next;
    logic                 accept, last_bit;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d           = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
    end

    assign res_full = {d, res_sr};
    assign accept   = start && (state == IDLE || state == DONE);
    assign last_bit = (state == SHIFT) && (count == LAST_BIT);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = start ? SHIFT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: shift registers are reset too; an aborted operation leaves nothing behind.
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            a_msb  <= a[BIT_WIDTH-1];
            b_msb  <= b[BIT_WIDTH-1];
            borrow <= 1'b0;
            count  <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_full[BIT_WIDTH-1:1];
            borrow <= borrow_next;
            count  <= count + 1'b1;
            if (last_bit) begin
                diff       <= res_full;
                borrow_out <= borrow_next;
                // d is the result MSB on the final bit.
                overflow   <= (a_msb ^ b_msb) & (d ^ a_msb);
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed self-checking bench for serial_subtractor_nbit; an 8-bit instance for
// handshake scenarios and a 32-bit instance for random arithmetic against a model.
module tb_serial_subtractor_nbit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8, ov8;
    logic [7:0] diff8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, bo32, ov32;
    logic [31:0] diff32;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    serial_subtractor_nbit #(.BIT_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
    );

    serial_subtractor_nbit #(.BIT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .diff(diff32), .borrow_out(bo32), .overflow(ov32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One 8-bit operation; returns at the negedge where done is seen (or after the bound).
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, output int busy_cnt,
                           output bit got, output logic [7:0] d, output logic bo, output logic ov);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(negedge clk);
        start8 = 1'b0; a8 = ~a; b8 = ~b;
        busy_cnt = 0; got = 1'b0; d = 'x; bo = 1'bx; ov = 1'bx;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done8) begin
                got = 1'b1; d = diff8; bo = bo8; ov = ov8;
            end else begin
                if (busy8) busy_cnt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_op32(input logic [31:0] a, input logic [31:0] b, output bit got,
                            output logic [31:0] d, output logic bo, output logic ov);
        @(negedge clk);
        start32 = 1'b1; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        got = 1'b0; d = 'x; bo = 1'bx; ov = 1'bx;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done32) begin
                got = 1'b1; d = diff32; bo = bo32; ov = ov32;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({busy8, done8, diff8, bo8, ov8} !== 12'h000) begin
            fails++;
            $display("FAIL reset8_outputs: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy8, done8, diff8, bo8, ov8);
        end
        tests++;
        if ({busy32, done32, diff32, bo32, ov32} !== 36'h0) begin
            fails++;
            $display("FAIL reset32_outputs: got busy=%b done=%b diff=%h, want all 0", busy32, done32, diff32);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
        end
    endtask

    task automatic test_basic();
        int bc; bit got; logic [7:0] d; logic bo, ov;
        run_op8(8'h5A, 8'h23, bc, got, d, bo, ov);
        tests++;
        if (!got) begin fails++; $display("FAIL basic_done: no done pulse within bound"); end
        tests++;
        if (bc != 8) begin fails++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
        tests++;
        if ({d, bo, ov} !== {8'h37, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: got diff=%h bo=%b ov=%b, want 37 0 0", d, bo, ov);
        end
        @(negedge clk);
        tests++;
        if (done8 !== 1'b0 || diff8 !== 8'h37) begin
            fails++;
            $display("FAIL basic_hold: got done=%b diff=%h, want done=0 diff=37", done8, diff8);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta[3] = '{8'h03, 8'h80, 8'hC3};
        logic [7:0] tb_[3] = '{8'h05, 8'h01, 8'hC3};
        logic [7:0] ed[3] = '{8'hFE, 8'h7F, 8'h00};
        logic       eb[3] = '{1'b1, 1'b0, 1'b0};
        logic       eo[3] = '{1'b0, 1'b1, 1'b0};
        int bc; bit got; logic [7:0] d; logic bo, ov;
        for (int k = 0; k < 3; k++) begin
            run_op8(ta[k], tb_[k], bc, got, d, bo, ov);
            tests++;
            if (!got || {d, bo, ov} !== {ed[k], eb[k], eo[k]}) begin
                fails++;
                $display("FAIL corner_%0d: got done=%b diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                         k, got, d, bo, ov, ed[k], eb[k], eo[k]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [7:0] d = 'x;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin pulses++; d = diff8; end
            @(negedge clk);
        end
        tests++;
        if (pulses != 1) begin fails++; $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses); end
        tests++;
        if (d !== 8'h0F) begin fails++; $display("FAIL ignore_diff: got %h, want 0f", d); end
    endtask

    task automatic test_abort();
        int bc; bit got; logic [7:0] d; logic bo, ov;
        int pulses = 0;
        run_op8(8'h00, 8'h80, bc, got, d, bo, ov);
        tests++;
        if (!got || {d, bo, ov} !== {8'h80, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL pre_abort: got diff=%h bo=%b ov=%b, want 80 1 1", d, bo, ov);
        end
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (busy8 !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b, want 1", busy8); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy8, done8, diff8, bo8, ov8} !== 12'h000) begin
            fails++;
            $display("FAIL abort_reset: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
                     busy8, done8, diff8, bo8, ov8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (done8) pulses++;
            @(negedge clk);
        end
        tests++;
        if (pulses != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses, want 0", pulses); end
        run_op8(8'h09, 8'h04, bc, got, d, bo, ov);
        tests++;
        if (!got || bc != 8 || d !== 8'h05) begin
            fail_line_abort: begin
                fails++;
                $display("FAIL abort_recover: got done=%b busy_cycles=%0d diff=%h, want 1 8 05", got, bc, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] oa[4] = '{8'h12, 8'hA0, 8'h7F, 8'h00};
        logic [7:0] ob[4] = '{8'h34, 8'h0A, 8'hFF, 8'h00};
        logic [7:0] ed[4] = '{8'hDE, 8'h96, 8'h80, 8'h00};
        int last_cyc = 0;
        bit got;
        @(negedge clk);
        a8 = oa[0]; b8 = ob[0]; start8 = 1'b1;
        @(negedge clk);
        a8 = oa[1]; b8 = ob[1];
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 12 && !got; i++) begin
                if (done8) got = 1'b1;
                else @(negedge clk);
            end
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL b2b_done_%0d: no done pulse within bound", k);
            end else begin
                tests++;
                if (diff8 !== ed[k]) begin
                    fails++;
                    $display("FAIL b2b_diff_%0d: got %h, want %h", k, diff8, ed[k]);
                end
                if (k > 0) begin
                    tests++;
                    if (cyc - last_cyc != 9) begin
                        fails++;
                        $display("FAIL b2b_period_%0d: got %0d cycles, want 9", k, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
            end
            if (k == 3) start8 = 1'b0;
            @(negedge clk);
            if (k + 2 < 4) begin a8 = oa[k+2]; b8 = ob[k+2]; end
        end
    endtask

    task automatic test_random32();
        logic [31:0] corner[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] a, b, d, ed;
        logic [32:0] m;
        logic bo, ov, eo;
        bit got;
        for (int n = 0; n < 1009; n++) begin
            if (n < 9) begin a = corner[n / 3]; b = corner[n % 3]; end
            else begin a = $urandom; b = $urandom; end
            m  = {1'b0, a} - {1'b0, b};
            ed = m[31:0];
            eo = (a[31] != b[31]) && (ed[31] != a[31]);
            run_op32(a, b, got, d, bo, ov);
            tests++;
            if (!got || {d, bo, ov} !== {ed, m[32], eo}) begin
                fails++;
                $display("FAIL rand32_%0d: a=%h b=%h got done=%b diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b",
                         n, a, b, got, d, bo, ov, ed, m[32], eo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random32();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
